regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
Parametrised successor to the CPU integer register file, with configurable data width, depth and read-port count. Reads are asynchronous and there is one synchronous write port. Register 0 is optionally hardwired to zero. After reset, a clear state machine zeroes every entry, one per cycle, and holds ready low until the clear completes. Sits in the CPU decode/writeback path; also reusable for FPU/vector register banks.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries
NUM_READ_PORTS, 2, number of independent asynchronous read ports (>=1)
ZERO_REG, 1, 1: entry 0 reads as zero and writes to it are dropped; 0: entry 0 is ordinary storage
CLEAR_ON_RESET, 1, 1: run the clear sequence after reset; 0: skip it, contents undefined

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
ready  output  1  high when clear has finished and the port accepts writes and returns valid reads
read_addr  input  NUM_READ_PORTS*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
read_data  output  NUM_READ_PORTS*DATA_WIDTH  packed read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
write_enable  input  1  write strobe
write_addr  input  ADDR_WIDTH  write address
write_data  input  DATA_WIDTH  write data

Behaviour:
- Reset values (asynchronous assertion):
  - state = CLEAR if CLEAR_ON_RESET, else IDLE_INIT.
  - clear_cnt = 0; ready = 0.
  - Storage array is not reset directly.
- FSM states: CLEAR, IDLE_INIT, READY.
  - CLEAR: each rising edge writes zero to entry clear_cnt, then clear_cnt++. On the edge that writes entry DEPTH-1, go to READY and set ready=1. ready therefore rises on the DEPTH-th rising edge after reset release (32 with defaults).
  - IDLE_INIT: go to READY and set ready=1 on the first rising edge after reset release.
  - READY: terminal state until the next reset.
- Reset asserted mid-clear: abort immediately. ready=0, clear_cnt=0. The clear restarts from entry 0 after release.
- clear_cnt is ADDR_WIDTH+1 bits wide or compared before increment, so it never wraps back into a re-clear.
- Writes:
  - Taken on a rising edge only when ready=1 and write_enable=1.
  - Dropped when write_addr==0 and ZERO_REG=1.
  - Written data is visible on read_data combinationally, after the edge that commits it (zero-cycle read latency, one-cycle write-to-read latency without the optional feature).
  - Writes while ready=0 are silently ignored; no error flag.
- Reads:
  - Purely combinational from read_addr; every port is independent.
  - Multiple ports may read the same address simultaneously.
  - Port forced to 0 when its address is 0 and ZERO_REG=1.
  - All ports forced to 0 while ready=0, so consumers never see uncleared X.
- No read/write hazard exists inside the array: an edge write and a combinational read of the same address return the old value until the edge.
- Width rules: no arithmetic on data; addresses are used unsigned at full ADDR_WIDTH.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined: when ready=1, write_enable=1 and read_addr[i]==write_addr (and not the dropped zero-register case), read_data[i] returns write_data in the same cycle (combinational forwarding). ZERO_REG and ready forcing still take priority.
- Undefined: no forwarding; read returns the stored value until the write edge.

Test Plan:
- Clear sequence: defaults, release reset, count edges -> ready=0 for 31 edges, rises on edge 32; all 32 entries then read 0 on both ports.
- Reset mid-clear: assert reset_n low after 10 clear edges, release -> ready low again, rises 32 edges after the second release; entries read 0.
- Write/read: write 0xDEADBEEF to entry 5 -> read port 0 at addr 5 returns 0xDEADBEEF after the edge; read port 1 at addr 5 returns the same value simultaneously.
- Zero register: write 0x12345678 to entry 0 -> both ports read 0 at addr 0. With ZERO_REG=0, the same write reads back 0x12345678.
- Ignored writes: write 0xAAAA5555 to entry 7 while ready=0 (during clear) -> entry 7 reads 0 after ready rises.
- Bypass: same-cycle write 0xCAFEF00D to entry 9 with read_addr port 1 = 9 -> with REGFILE_WRITE_BYPASS_EN port 1 shows 0xCAFEF00D before the edge; without it, port 1 shows the previous value 0 before the edge and 0xCAFEF00D after.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised register file: N asynchronous read ports, one synchronous write port,
// optional hardwired zero register and post-reset clear. Optional macro: REGFILE_WRITE_BYPASS_EN.
module regfile_multiport #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int ZERO_REG       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    output logic                                 ready,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    input  logic                                 write_enable,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_WIDTH-1:0]                write_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE_INIT,
        S_READY
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_clear_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_zero_drop;
    logic w_user_we;
    logic w_clear_we;

    assign ready       = r_ready;
    assign w_zero_drop = (ZERO_REG != 0) && (write_addr == '0);
    assign w_user_we   = r_ready && write_enable && !w_zero_drop;
    assign w_clear_we  = (r_state == S_CLEAR);

    // The counter carries one extra bit so it can never wrap back into a second clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE_INIT;
            r_clear_cnt <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clear_cnt <= r_clear_cnt + 1'b1;
                    if (r_clear_cnt == CNT_W'(DEPTH - 1)) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE_INIT: begin
                    r_state <= S_READY;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_READY;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; resetting every entry would turn the
    // RAM into a flop bank. The clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_clear_cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (w_user_we) begin
            r_mem[write_addr] <= write_data;
        end
    end

    for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_force_zero;

        assign w_addr       = read_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_force_zero = !r_ready || ((ZERO_REG != 0) && (w_addr == '0));

`ifdef REGFILE_WRITE_BYPASS_EN
        logic w_fwd;
        assign w_fwd = w_user_we && (w_addr == write_addr);
        assign read_data[g*DATA_WIDTH +: DATA_WIDTH] =
            w_force_zero ? '0 : (w_fwd ? write_data : r_mem[w_addr]);
`else
        assign read_data[g*DATA_WIDTH +: DATA_WIDTH] =
            w_force_zero ? '0 : r_mem[w_addr];
`endif
    end

endmodule
